// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the load/store unit: access sizes, FSM states, default width
// and the alignment rule used when a request is accepted.
package mem_lsu_pkg;

    localparam int MEM_WIDTH = 32;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_X = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_RESP = 2'b11
    } state_e;

    // Illegal size counts as misaligned so both error causes share one path.
    function automatic logic misaligned(size_e size, logic [1:0] lo);
        case (size)
            SIZE_B:  return 1'b0;
            SIZE_H:  return lo[0];
            SIZE_W:  return |lo;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extraction with sign/zero extension for loads, read-modify-write merge for stores.
// Purely combinational (zero latency); no flow control.
module lsu_align
    import mem_lsu_pkg::*;
#(
    parameter int MemWidth = MEM_WIDTH
) (
    input  logic [1:0]          size,
    input  logic                uns,
    input  logic [1:0]          addr_lo,
    input  logic [MemWidth-1:0] rdata,
    input  logic [MemWidth-1:0] wdata,
    output logic [MemWidth-1:0] load_data,
    output logic [MemWidth-1:0] store_data
);

    logic [7:0]          byte_sel;
    logic [15:0]         half_sel;
    logic [4:0]          shamt;
    logic [MemWidth-1:0] mask;
    logic [MemWidth-1:0] ins;

    always_comb begin
        byte_sel  = rdata[{addr_lo, 3'b000} +: 8];
        half_sel  = rdata[{addr_lo[1], 4'b0000} +: 16];
        shamt     = (size == SIZE_H) ? {addr_lo[1], 4'b0000} : {addr_lo, 3'b000};
        load_data = rdata;
        mask      = '1;
        ins       = wdata;
        case (size)
            SIZE_B: begin
                load_data = {{(MemWidth-8){~uns & byte_sel[7]}}, byte_sel};
                mask      = {{(MemWidth-8){1'b0}}, 8'hFF} << shamt;
                ins       = {{(MemWidth-8){1'b0}}, wdata[7:0]} << shamt;
            end
            SIZE_H: begin
                load_data = {{(MemWidth-16){~uns & half_sel[15]}}, half_sel};
                mask      = {{(MemWidth-16){1'b0}}, 16'hFFFF} << shamt;
                ins       = {{(MemWidth-16){1'b0}}, wdata[15:0]} << shamt;
            end
            default: ;
        endcase
        // Word stores fall through with an all-ones mask, i.e. plain wdata.
        store_data = (rdata & ~mask) | (ins & mask);
    end

endmodule

// File: rtl/mem_lsu.sv
// Single-outstanding load/store unit on a word RAM; load/word store 2 cycles, sub-word 3, error 1.
// Accepts only in IDLE (ready low while busy or in reset); response pulse has no backpressure.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int MemWidth = MEM_WIDTH
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_we_i,
    input  logic [1:0]          req_size_i,
    input  logic                req_unsigned_i,
    input  logic [MemWidth-1:0] req_addr_i,
    input  logic [MemWidth-1:0] req_wdata_i,
    output logic                rsp_valid_o,
    output logic [MemWidth-1:0] rsp_rdata_o,
    output logic                rsp_err_o,
    output logic                mem_wen_o,
    output logic [MemWidth-1:0] mem_waddr_o,
    output logic [MemWidth-1:0] mem_wdata_o,
    output logic [MemWidth-1:0] mem_raddr_o,
    input  logic [MemWidth-1:0] mem_rdata_i
);

    typedef struct packed {
        logic                we;
        size_e               size;
        logic                uns;
        logic [MemWidth-1:0] addr;
        logic [MemWidth-1:0] wdata;
    } req_t;

    state_e              state;
    req_t                req_q;
    logic                wen_q;
    logic [MemWidth-1:0] load_data;
    logic [MemWidth-1:0] store_data;

    lsu_align #(.MemWidth(MemWidth)) u_align (
        .size       (req_q.size),
        .uns        (req_q.uns),
        .addr_lo    (req_q.addr[1:0]),
        .rdata      (mem_rdata_i),
        .wdata      (req_q.wdata),
        .load_data  (load_data),
        .store_data (store_data)
    );

    assign req_ready_o = (state == ST_IDLE) && !rst_i;
    // Gating with reset keeps the RAM untouched when reset lands during WR.
    assign mem_wen_o   = wen_q && !rst_i;
    assign mem_raddr_o = {req_q.addr[MemWidth-1:2], 2'b00};
    assign mem_waddr_o = {req_q.addr[MemWidth-1:2], 2'b00};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            req_q       <= '0;
            wen_q       <= 1'b0;
            mem_wdata_o <= '0;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
        end else begin
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
            wen_q       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        req_q <= '{we:    req_we_i,
                                   size:  size_e'(req_size_i),
                                   uns:   req_unsigned_i,
                                   addr:  req_addr_i,
                                   wdata: req_wdata_i};
                        if (misaligned(size_e'(req_size_i), req_addr_i[1:0])) begin
                            state       <= ST_RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b1;
                        end else if (req_we_i && size_e'(req_size_i) == SIZE_W) begin
                            state       <= ST_WR;
                            wen_q       <= 1'b1;
                            mem_wdata_o <= req_wdata_i;
                        end else begin
                            state <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (req_q.we) begin
                        state       <= ST_WR;
                        wen_q       <= 1'b1;
                        mem_wdata_o <= store_data;
                    end else begin
                        state       <= ST_RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_rdata_o <= load_data;
                    end
                end
                ST_WR: begin
                    state       <= ST_RESP;
                    rsp_valid_o <= 1'b1;
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a word RAM model and hand-computed expectations.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        mem_wen_o;
    logic [31:0] mem_waddr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_raddr_o;
    logic [31:0] mem_rdata_i;

    logic [31:0] ram [0:63];
    int vectors = 0;
    int errors  = 0;
    int wen_cnt = 0;
    int rsp_cnt = 0;
    int acc_cnt = 0;

    always #5 clk = ~clk;

    mem_lsu #(.MemWidth(32)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_err_o      (rsp_err_o),
        .mem_wen_o      (mem_wen_o),
        .mem_waddr_o    (mem_waddr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_raddr_o    (mem_raddr_o),
        .mem_rdata_i    (mem_rdata_i)
    );

    assign mem_rdata_i = ram[mem_raddr_o[7:2]];

    always @(posedge clk) begin
        if (mem_wen_o) begin
            ram[mem_waddr_o[7:2]] <= mem_wdata_o;
            wen_cnt <= wen_cnt + 1;
        end
        if (rsp_valid_o) rsp_cnt <= rsp_cnt + 1;
        if (req_valid_i && req_ready_o) acc_cnt <= acc_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input int exp_lat,
                       input logic [31:0] exp_rd, input logic exp_err, input int exp_wens);
        int          w0;
        int          n;
        int          lat;
        logic [31:0] rd;
        logic        er;
        @(negedge clk);
        n = 0;
        while (!req_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        req_valid_i    = 1'b1;
        req_we_i       = we;
        req_size_i     = sz;
        req_unsigned_i = uns;
        req_addr_i     = a;
        req_wdata_i    = wd;
        w0 = wen_cnt;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        lat = 99;
        rd  = 'x;
        er  = 1'bx;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (rsp_valid_o) begin
                lat = i;
                rd  = rsp_rdata_o;
                er  = rsp_err_o;
                break;
            end
        end
        chk({tag, ".lat"}, lat, exp_lat);
        chk({tag, ".rdata"}, rd, exp_rd);
        chk({tag, ".err"}, 32'(er), 32'(exp_err));
        @(negedge clk);
        chk({tag, ".pulse"}, 32'(rsp_valid_o), 32'd0);
        chk({tag, ".wen"}, wen_cnt - w0, exp_wens);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int r0;
        int w0;
        int a0;
        for (int i = 0; i < 64; i++) ram[i] = 32'h0;
        rst_i = 1'b1;
        req_valid_i = 1'b0;
        req_we_i = 1'b0;
        req_size_i = 2'b00;
        req_unsigned_i = 1'b0;
        req_addr_i = 32'h0;
        req_wdata_i = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.ready", 32'(req_ready_o), 32'd0);
        chk("rst.rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst.rsp_err", 32'(rsp_err_o), 32'd0);
        chk("rst.rsp_rdata", rsp_rdata_o, 32'h0);
        chk("rst.wen", 32'(mem_wen_o), 32'd0);
        chk("rst.wdata", mem_wdata_o, 32'h0);
        chk("rst.raddr", mem_raddr_o, 32'h0);
        chk("rst.waddr", mem_waddr_o, 32'h0);
        @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("rst.ready_after", 32'(req_ready_o), 32'd1);

        // Word store then load
        run("sw10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1);
        chk("ram10", ram[4], 32'hDEADBEEF);
        run("lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 32'hDEADBEEF, 1'b0, 0);

        // Sub-word stores via read-modify-write
        run("sw20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 2, 32'h0, 1'b0, 1);
        run("sb21", 1'b1, 2'b00, 1'b0, 32'h21, 32'h555555AA, 3, 32'h0, 1'b0, 1);
        chk("ram20_sb", ram[8], 32'h1122AA44);
        run("sh22", 1'b1, 2'b01, 1'b0, 32'h22, 32'h7777BEEF, 3, 32'h0, 1'b0, 1);
        chk("ram20_sh", ram[8], 32'hBEEFAA44);

        // Lane extraction and extension
        run("sw30", 1'b1, 2'b10, 1'b0, 32'h30, 32'h80FF7F01, 2, 32'h0, 1'b0, 1);
        run("lb33", 1'b0, 2'b00, 1'b0, 32'h33, 32'h0, 2, 32'hFFFFFF80, 1'b0, 0);
        run("lbu33", 1'b0, 2'b00, 1'b1, 32'h33, 32'h0, 2, 32'h00000080, 1'b0, 0);
        run("lh32", 1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 2, 32'hFFFF80FF, 1'b0, 0);
        run("lhu30", 1'b0, 2'b01, 1'b1, 32'h30, 32'h0, 2, 32'h00007F01, 1'b0, 0);
        run("lb31", 1'b0, 2'b00, 1'b0, 32'h31, 32'h0, 2, 32'h0000007F, 1'b0, 0);

        // Error cases
        run("lw32_mis", 1'b0, 2'b10, 1'b0, 32'h32, 32'h0, 1, 32'h0, 1'b1, 0);
        run("sh31_mis", 1'b1, 2'b01, 1'b0, 32'h31, 32'h0000CAFE, 1, 32'h0, 1'b1, 0);
        run("size11", 1'b1, 2'b11, 1'b0, 32'h30, 32'h12345678, 1, 32'h0, 1'b1, 0);
        chk("ram30_err", ram[12], 32'h80FF7F01);

        // Reset during WR of a byte store
        @(negedge clk);
        req_valid_i = 1'b1;
        req_we_i = 1'b1;
        req_size_i = 2'b00;
        req_unsigned_i = 1'b0;
        req_addr_i = 32'h31;
        req_wdata_i = 32'h00000011;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        @(posedge clk);
        #1;
        chk("abort.wen_in_wr", 32'(mem_wen_o), 32'd1);
        rst_i = 1'b1;
        r0 = rsp_cnt;
        w0 = wen_cnt;
        #1;
        chk("abort.wen_gated", 32'(mem_wen_o), 32'd0);
        @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("abort.ready", 32'(req_ready_o), 32'd1);
        repeat (4) @(negedge clk);
        chk("abort.no_rsp", rsp_cnt - r0, 0);
        chk("abort.no_wen", wen_cnt - w0, 0);
        chk("abort.ram", ram[12], 32'h80FF7F01);

        // Valid held high across back-to-back loads
        @(negedge clk);
        a0 = acc_cnt;
        r0 = rsp_cnt;
        req_valid_i = 1'b1;
        req_we_i = 1'b0;
        req_size_i = 2'b10;
        req_addr_i = 32'h10;
        repeat (12) @(posedge clk);
        #1 req_valid_i = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("b2b.accepts", acc_cnt - a0, 4);
        chk("b2b.rsps", rsp_cnt - r0, 4);
        chk("b2b.rdata_after", rsp_rdata_o, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
